// File: rtl/kbd_port_pkg.sv
// Shared register map and STATUS/CTRL bit positions for the keyboard host port.
package kbd_port_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_COUNT  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int unsigned ST_AVAIL  = 0;
    localparam int unsigned ST_FULL   = 1;
    localparam int unsigned ST_OVF    = 2;
    localparam int unsigned ST_IRQ_EN = 3;
    localparam int unsigned ST_IRQ    = 7;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVF = 2;
    localparam int unsigned CTRL_IRQ_EN  = 3;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with push/pop/flush; head byte is always visible on dout.
module sync_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // A push into a full FIFO still lands when the same edge pops a slot free.
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/kbd_host_port.sv
// Keyboard byte receive port: FIFO buffering, CPU register interface and interrupt.
module kbd_host_port
    import kbd_port_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq_n
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          push, pop, flush, ctrl_wr, drop;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_n_q, irq_n_d;
    logic [7:0]    status;
    logic          unused_wdata;

    assign in_ready     = reset_n;
    assign push         = in_valid && in_ready;
    assign pop          = cs && !we && (addr == REG_DATA);
    assign ctrl_wr      = cs && we && (addr == REG_STATUS);
    assign flush        = ctrl_wr && wdata[CTRL_FLUSH];
    assign unused_wdata = ^{wdata[7:4], wdata[1]};
    // A flush swallows a concurrent push silently, so it never counts as a drop.
    assign drop         = push && full && !(pop && !empty) && !flush;

    sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (in_data),
        .dout   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            irq_en_d = wdata[CTRL_IRQ_EN];
            if (wdata[CTRL_CLR_OVF]) begin
                ovf_d = 1'b0;
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        irq_n_d = !(irq_en_q && !empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_n_q  <= 1'b1;
        end else begin
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;

    always_comb begin
        status            = '0;
        status[ST_AVAIL]  = !empty;
        status[ST_FULL]   = full;
        status[ST_OVF]    = ovf_q;
        status[ST_IRQ_EN] = irq_en_q;
        status[ST_IRQ]    = irq_en_q && !empty;
        rdata             = '0;
        case (reg_addr_e'(addr))
            REG_DATA:   rdata = empty ? 8'h00 : head;
            REG_STATUS: rdata = status;
            REG_COUNT:  rdata = {{(8 - CW){1'b0}}, count};
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_kbd_host_port.sv
// Directed self-checking bench for kbd_host_port (DEPTH = 8).
module tb_kbd_host_port;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_n;

    int unsigned tests = 0;
    int unsigned fails = 0;

    kbd_host_port #(.DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_n   (irq_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        cs   = 1'b1;
        we   = 1'b0;
        addr = 2'd0;
        #1;
        check(tag, rdata, exp);
        tick();
        cs = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [7:0] v);
        cs    = 1'b1;
        we    = 1'b1;
        addr  = 2'd1;
        wdata = v;
        tick();
        cs = 1'b0;
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        cs       = 1'b0;
        we       = 1'b0;
        addr     = 2'd0;
        wdata    = '0;
        #12;
        check("rst_in_ready", {7'b0, in_ready}, 8'h00);
        check("rst_irq_n", {7'b0, irq_n}, 8'h01);
        peek("rst_status", 2'd1, 8'h00);
        peek("rst_count", 2'd2, 8'h00);
        reset_n = 1'b1;
        #1;
        check("in_ready_up", {7'b0, in_ready}, 8'h01);
        tick();
        peek("empty_data", 2'd0, 8'h00);

        // Basic push and read-back
        push(8'h41);
        push(8'h42);
        peek("t1_status", 2'd1, 8'h01);
        peek("t1_count", 2'd2, 8'h02);
        pop_check("t1_data0", 8'h41);
        pop_check("t1_data1", 8'h42);
        peek("t1_status_end", 2'd1, 8'h00);

        // Overflow: ninth byte is dropped
        for (int i = 1; i <= 9; i++) push(8'(i));
        peek("t2_status", 2'd1, 8'h07);
        peek("t2_count", 2'd2, 8'h08);
        for (int i = 1; i <= 8; i++) pop_check("t2_data", 8'(i));
        peek("t2_status_ovf", 2'd1, 8'h04);
        peek("t2_count_end", 2'd2, 8'h00);
        wr_ctrl(8'h04);
        peek("t2_ovf_clr", 2'd1, 8'h00);

        // Interrupt timing
        wr_ctrl(8'h08);
        peek("t3_status_en", 2'd1, 8'h08);
        check("t3_irq_idle", {7'b0, irq_n}, 8'h01);
        push(8'h0D);
        peek("t3_status_pend", 2'd1, 8'h89);
        check("t3_irq_lag", {7'b0, irq_n}, 8'h01);
        tick();
        check("t3_irq_low", {7'b0, irq_n}, 8'h00);
        pop_check("t3_data", 8'h0D);
        peek("t3_status_clr", 2'd1, 8'h08);
        check("t3_irq_still", {7'b0, irq_n}, 8'h00);
        tick();
        check("t3_irq_high", {7'b0, irq_n}, 8'h01);
        wr_ctrl(8'h00);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        peek("t4_count_full", 2'd2, 8'h08);
        in_valid = 1'b1;
        in_data  = 8'h55;
        cs       = 1'b1;
        we       = 1'b0;
        addr     = 2'd0;
        #1;
        check("t4_head", rdata, 8'h11);
        tick();
        in_valid = 1'b0;
        cs       = 1'b0;
        peek("t4_count", 2'd2, 8'h08);
        peek("t4_status", 2'd1, 8'h03);
        for (int i = 1; i < 8; i++) pop_check("t4_data", 8'h11 + 8'(i));
        pop_check("t4_last", 8'h55);
        peek("t4_count_end", 2'd2, 8'h00);

        // Push and pop together while partially full
        push(8'hA1);
        push(8'hA2);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        cs       = 1'b1;
        we       = 1'b0;
        addr     = 2'd0;
        tick();
        in_valid = 1'b0;
        cs       = 1'b0;
        peek("t4b_count", 2'd2, 8'h02);
        pop_check("t4b_data0", 8'hA2);
        pop_check("t4b_data1", 8'hA3);

        // Flush with concurrent push
        push(8'h31);
        push(8'h32);
        push(8'h33);
        in_valid = 1'b1;
        in_data  = 8'h77;
        cs       = 1'b1;
        we       = 1'b1;
        addr     = 2'd1;
        wdata    = 8'h05;
        tick();
        in_valid = 1'b0;
        cs       = 1'b0;
        we       = 1'b0;
        peek("t5_count", 2'd2, 8'h00);
        peek("t5_status", 2'd1, 8'h00);
        pop_check("t5_empty_data", 8'h00);
        peek("t5_count_end", 2'd2, 8'h00);

        // Clear-OVF loses to a simultaneous drop
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        in_valid = 1'b1;
        in_data  = 8'h99;
        cs       = 1'b1;
        we       = 1'b1;
        addr     = 2'd1;
        wdata    = 8'h04;
        tick();
        in_valid = 1'b0;
        cs       = 1'b0;
        we       = 1'b0;
        peek("t6_status", 2'd1, 8'h07);
        wr_ctrl(8'h05);
        peek("t6_flushed", 2'd1, 8'h00);

        // No pop without cs; writes to DATA ignored; reserved read
        push(8'hC3);
        addr = 2'd0;
        tick();
        peek("t7_nocs_count", 2'd2, 8'h01);
        cs    = 1'b1;
        we    = 1'b1;
        addr  = 2'd0;
        wdata = 8'hFF;
        tick();
        cs = 1'b0;
        we = 1'b0;
        peek("t7_wr0_count", 2'd2, 8'h01);
        peek("t7_wr0_data", 2'd0, 8'hC3);
        peek("t7_addr3", 2'd3, 8'h00);
        wr_ctrl(8'h01);

        // Asynchronous reset mid-operation
        wr_ctrl(8'h08);
        push(8'hE1);
        push(8'hE2);
        push(8'hE3);
        tick();
        peek("t8_count_pre", 2'd2, 8'h03);
        check("t8_irq_pre", {7'b0, irq_n}, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        addr = 2'd2;
        #0;
        check("t8_count_rst", rdata, 8'h00);
        check("t8_irq_rst", {7'b0, irq_n}, 8'h01);
        check("t8_ready_rst", {7'b0, in_ready}, 8'h00);
        peek("t8_status_rst", 2'd1, 8'h00);
        reset_n = 1'b1;
        push(8'hAB);
        peek("t8_data_post", 2'd0, 8'hAB);
        peek("t8_count_post", 2'd2, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
